inst_fetch_ctrl: RTL and testbench
==================================

// Module: inst_fetch_ctrl
// PURPOSE
//   Fetch sequencer for the instruction memory; owns the program counter (PC).
//   Drives the memory address, captures {pc, instruction} pairs into a small prefetch
//   FIFO, and presents them to decode with a valid/ready handshake.
//   Handles redirect (branch/flush) and decode back-pressure. Sits between instruction memory and the IF/ID register.
// PARAMETERS
//   RESET_PC    16'd8  PC loaded on reset (first program word sits at nibble address 8)
//   PC_STEP     4      nibble cells per instruction; PC increment per fetch
//   FIFO_DEPTH  2      prefetch entries (power of 2, >=2)
// PORTS
//   clk            in   1          clock, all state on rising edge
//   rst            in   1          asynchronous, active-high reset
//   imem_addr      out  WORD_LEN   address to instruction memory (= pc register, combinational from it)
//   imem_instr     in   WORD_LEN   instruction returned combinationally for imem_addr
//   branch_taken   in   1          redirect request from execute
//   branch_target  in   WORD_LEN   redirect address; bits [1:0] forced to 0 on load
//   dec_ready      in   1          decode accepts head entry this cycle
//   if_valid       out  1          head entry valid
//   if_instr       out  WORD_LEN   head instruction
//   if_pc          out  WORD_LEN   PC of head instruction
//   halted         out  1          fetch stopped by HALT (0 when FETCH_HALT_EN undefined)
// BEHAVIOUR
//   - Reset (async): pc=RESET_PC, FIFO empty (count=0, rd/wr ptr=0), state=RUN;
//     if_valid=0, if_instr=0, if_pc=0, halted=0. Reset mid-operation discards all entries immediately.
//   - pop = if_valid & dec_ready; push = (state==RUN) & ~branch_taken & (count<FIFO_DEPTH | pop).
//   - Push: write {pc, imem_instr} at wr_ptr; pc <= pc + PC_STEP, modulo 2^WORD_LEN (0xFFFC -> 0x0000).
//   - Outputs fall through from FIFO head: if_instr/if_pc = head entry, zero when empty.
//   - Latency: memory read and push in the same cycle; entry visible on if_valid the next cycle.
//   - Full with simultaneous pop: push allowed; count unchanged.
//   - Full without pop: no push, pc holds, imem_addr stable.
//   - Empty: if_valid=0; dec_ready ignored.
//   - Redirect: branch_taken has priority over push/pop.
//     Same edge: FIFO cleared (count=0), pc <= {branch_target[W-1:2],2'b00}, no push, pop suppressed.
//     Next cycle: fetch from target. Cycle after: target instruction valid on if_valid.
//   - Redirect while HALTED: returns state to RUN (restart path).
//   - count width = $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
//   - FSM: RUN --(halt fetched, macro only)--> HALTED --(branch_taken)--> RUN; rst -> RUN from any state.
// CONFIGURATION
//   FETCH_HALT_EN defined:
//     - A pushed instruction with imem_instr[15:12]==4'b1111 is still enqueued (decode sees it).
//     - State -> HALTED the same edge. No further pushes; pc frozen at halt PC + PC_STEP; halted=1 while HALTED.
//   FETCH_HALT_EN undefined:
//     - Opcode 4'b1111 is fetched like any other; state never leaves RUN; halted tied 0.
// TESTING
//   1. Reset release, dec_ready=1, mem words at 8/12/16 = 16'h310A/16'h320B/16'h3303
//      -> imem_addr 8,12,16,...; if_valid from cycle 2; (if_pc,if_instr) = (8,310A),(12,320B),(16,3303).
//   2. dec_ready=0 for 5 cycles after reset
//      -> count saturates at 2 (pc 8,12 held); imem_addr holds 16; on dec_ready=1 entries drain in order, no loss/dup.
//   3. branch_taken=1 with target 16'h0031 while FIFO full
//      -> next cycle if_valid=0, imem_addr=0x0030; following cycle if_pc=0x0030.
//   4. pc reaches 0xFFFC, dec_ready=1 -> next fetch address 0x0000, entries (FFFC,x),(0000,y).
//   5. rst asserted mid-stream with 2 entries queued
//      -> immediately if_valid=0, imem_addr=8; after release, stream restarts at PC 8.
//   6. FETCH_HALT_EN: word 16'hF000 at 20 -> delivered at if_pc=20, halted=1, imem_addr frozen at 24;
//      branch_taken to 8 -> halted=0, refetch from 8. Macro off: 16'hF000 passes, halted stays 0.

Source files
------------

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory port, redirect input and decode handshake.
// master = fetch controller, slave = surrounding pipeline / memory.
interface inst_fetch_ctrl_if #(
  parameter int WORD_LEN = 16
);
  logic [WORD_LEN-1:0] imem_addr;
  logic [WORD_LEN-1:0] imem_instr;
  logic                branch_taken;
  logic [WORD_LEN-1:0] branch_target;
  logic                dec_ready;
  logic                if_valid;
  logic [WORD_LEN-1:0] if_instr;
  logic [WORD_LEN-1:0] if_pc;
  logic                halted;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, halted,
    input  imem_instr, branch_taken, branch_target, dec_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, halted,
    output imem_instr, branch_taken, branch_target, dec_ready
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, fills a small prefetch FIFO, hands {pc, instr} to decode.
// Optional HALT-opcode stop is enabled by defining FETCH_HALT_EN.
module inst_fetch_ctrl #(
  parameter int                  WORD_LEN   = 16,
  parameter logic [WORD_LEN-1:0] RESET_PC   = 'd8,
  parameter int                  PC_STEP    = 4,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_ctrl_if.master  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [WORD_LEN-1:0] pc_reg, pc_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;

  logic [WORD_LEN-1:0] pc_mem    [FIFO_DEPTH];
  logic [WORD_LEN-1:0] instr_mem [FIFO_DEPTH];

  logic not_empty, pop, push, halt_fetch;

  assign not_empty = (count_reg != '0);
  // Redirect wins: a same-cycle pop would retire an entry that is being flushed anyway.
  assign pop  = not_empty & bus.dec_ready & ~bus.branch_taken;
  assign push = (state_reg == RUN) & ~bus.branch_taken &
                ((count_reg < CNT_W'(FIFO_DEPTH)) | pop);

`ifdef FETCH_HALT_EN
  assign halt_fetch = push & (bus.imem_instr[WORD_LEN-1 -: 4] == 4'b1111);
  assign bus.halted = (state_reg == HALTED);
`else
  assign halt_fetch = 1'b0;
  assign bus.halted = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (bus.branch_taken) begin
      state_next  = RUN;
      pc_next     = {bus.branch_target[WORD_LEN-1:2], 2'b00};
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (halt_fetch)
        state_next = HALTED;
      if (push) begin
        pc_next     = pc_reg + WORD_LEN'(PC_STEP);
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop)
        rd_ptr_next = rd_ptr_reg + 1'b1;
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= RUN;
      pc_reg     <= RESET_PC;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  // Storage needs no reset: entries are only visible while count says they are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= pc_reg;
      instr_mem[wr_ptr_reg] <= bus.imem_instr;
    end
  end

  assign bus.imem_addr = pc_reg;
  assign bus.if_valid  = not_empty;
  assign bus.if_pc     = not_empty ? pc_mem[rd_ptr_reg]    : '0;
  assign bus.if_instr  = not_empty ? instr_mem[rd_ptr_reg] : '0;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl with a combinational instruction-memory model.
module tb_inst_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic place_halt = 1'b0;
  int   checks = 0;
  int   failures = 0;

  inst_fetch_ctrl_if #(.WORD_LEN(16)) bus ();

  inst_fetch_ctrl #(
    .WORD_LEN(16), .RESET_PC(16'd8), .PC_STEP(4), .FIFO_DEPTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Program words from the test plan; elsewhere {4'h2, addr[11:0]} so every word is traceable.
  always_comb begin
    case (bus.imem_addr)
      16'd8:   bus.imem_instr = 16'h310A;
      16'd12:  bus.imem_instr = 16'h320B;
      16'd16:  bus.imem_instr = 16'h3303;
      16'd20:  bus.imem_instr = place_halt ? 16'hF000 : 16'h2014;
      default: bus.imem_instr = {4'h2, bus.imem_addr[11:0]};
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0000;
    bus.dec_ready     = rdy;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0000;
    bus.dec_ready     = 1'b1;
    #12;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.if_pc !== 16'h0 || bus.if_instr !== 16'h0 ||
        bus.halted !== 1'b0 || bus.imem_addr !== 16'd8) begin
      failures++;
      $display("FAIL reset: valid=%b pc=%h instr=%h halted=%b addr=%h, required 0/0000/0000/0/0008",
               bus.if_valid, bus.if_pc, bus.if_instr, bus.halted, bus.imem_addr);
    end
    $display("reset: valid=%b addr=%h", bus.if_valid, bus.imem_addr);
  endtask

  task automatic test_stream();
    logic [15:0] exp_pc [3];
    logic [15:0] exp_in [3];
    exp_pc = '{16'd8, 16'd12, 16'd16};
    exp_in = '{16'h310A, 16'h320B, 16'h3303};
    do_reset(1'b1);
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 16'd8) begin
      failures++;
      $display("FAIL stream_start: valid=%b addr=%h, required 0/0008", bus.if_valid, bus.imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc[k] || bus.if_instr !== exp_in[k] ||
          bus.imem_addr !== exp_pc[k] + 16'd4) begin
        failures++;
        $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h addr=%h, required 1/%h/%h/%h",
                 k, bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_addr,
                 exp_pc[k], exp_in[k], exp_pc[k] + 16'd4);
      end
      $display("stream: pc=%h instr=%h addr=%h", bus.if_pc, bus.if_instr, bus.imem_addr);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_pc [3];
    exp_pc = '{16'd8, 16'd12, 16'd16};
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k >= 1) begin
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'd8 || bus.imem_addr !== 16'd16) begin
          failures++;
          $display("FAIL hold[%0d]: valid=%b pc=%h addr=%h, required 1/0008/0010",
                   k, bus.if_valid, bus.if_pc, bus.imem_addr);
        end
      end
      $display("hold: pc=%h addr=%h", bus.if_pc, bus.imem_addr);
    end
    bus.dec_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      step();
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc[k] || bus.imem_addr !== 16'd16 + 16'd4 * k) begin
        failures++;
        $display("FAIL drain[%0d]: valid=%b pc=%h addr=%h, required 1/%h/%h",
                 k, bus.if_valid, bus.if_pc, bus.imem_addr, exp_pc[k], 16'd16 + 16'd4 * k);
      end
      $display("drain: pc=%h addr=%h", bus.if_pc, bus.imem_addr);
    end
  endtask

  task automatic test_branch();
    do_reset(1'b0);
    step();
    step();
    bus.dec_ready     = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0031;
    step();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 16'h0030) begin
      failures++;
      $display("FAIL branch_flush: valid=%b addr=%h, required 0/0030", bus.if_valid, bus.imem_addr);
    end
    step();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'h0030 || bus.if_instr !== 16'h2030 ||
        bus.imem_addr !== 16'h0034) begin
      failures++;
      $display("FAIL branch_target: valid=%b pc=%h instr=%h addr=%h, required 1/0030/2030/0034",
               bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_addr);
    end
    $display("branch: pc=%h instr=%h", bus.if_pc, bus.if_instr);
  endtask

  task automatic test_wrap();
    bus.dec_ready     = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'hFFFE;
    step();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 16'hFFFC) begin
      failures++;
      $display("FAIL wrap_load: valid=%b addr=%h, required 0/FFFC", bus.if_valid, bus.imem_addr);
    end
    step();
    checks++;
    if (bus.if_pc !== 16'hFFFC || bus.if_instr !== 16'h2FFC || bus.imem_addr !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_top: pc=%h instr=%h addr=%h, required FFFC/2FFC/0000",
               bus.if_pc, bus.if_instr, bus.imem_addr);
    end
    step();
    checks++;
    if (bus.if_pc !== 16'h0000 || bus.if_instr !== 16'h2000 || bus.imem_addr !== 16'h0004) begin
      failures++;
      $display("FAIL wrap_zero: pc=%h instr=%h addr=%h, required 0000/2000/0004",
               bus.if_pc, bus.if_instr, bus.imem_addr);
    end
    $display("wrap: pc=%h addr=%h", bus.if_pc, bus.imem_addr);
  endtask

  task automatic test_reset_midstream();
    do_reset(1'b0);
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.if_pc !== 16'h0 || bus.imem_addr !== 16'd8) begin
      failures++;
      $display("FAIL midreset: valid=%b pc=%h addr=%h, required 0/0000/0008",
               bus.if_valid, bus.if_pc, bus.imem_addr);
    end
    step();
    rst = 1'b0;
    bus.dec_ready = 1'b1;
    step();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'd8 || bus.if_instr !== 16'h310A) begin
      failures++;
      $display("FAIL restart: valid=%b pc=%h instr=%h, required 1/0008/310A",
               bus.if_valid, bus.if_pc, bus.if_instr);
    end
    $display("midreset: restart pc=%h", bus.if_pc);
  endtask

  task automatic test_halt();
    place_halt = 1'b1;
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) step();
`ifdef FETCH_HALT_EN
    checks++;
    if (bus.if_pc !== 16'd20 || bus.if_instr !== 16'hF000 || bus.halted !== 1'b1 ||
        bus.imem_addr !== 16'd24) begin
      failures++;
      $display("FAIL halt_fetch: pc=%h instr=%h halted=%b addr=%h, required 0014/F000/1/0018",
               bus.if_pc, bus.if_instr, bus.halted, bus.imem_addr);
    end
    step();
    step();
    checks++;
    if (bus.if_valid !== 1'b0 || bus.halted !== 1'b1 || bus.imem_addr !== 16'd24) begin
      failures++;
      $display("FAIL halt_hold: valid=%b halted=%b addr=%h, required 0/1/0018",
               bus.if_valid, bus.halted, bus.imem_addr);
    end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'd8;
    step();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.halted !== 1'b0 || bus.imem_addr !== 16'd8) begin
      failures++;
      $display("FAIL halt_restart: halted=%b addr=%h, required 0/0008", bus.halted, bus.imem_addr);
    end
    step();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'd8 || bus.if_instr !== 16'h310A) begin
      failures++;
      $display("FAIL halt_refetch: valid=%b pc=%h instr=%h, required 1/0008/310A",
               bus.if_valid, bus.if_pc, bus.if_instr);
    end
`else
    checks++;
    if (bus.if_pc !== 16'd20 || bus.if_instr !== 16'hF000 || bus.halted !== 1'b0 ||
        bus.imem_addr !== 16'd24) begin
      failures++;
      $display("FAIL halt_off: pc=%h instr=%h halted=%b addr=%h, required 0014/F000/0/0018",
               bus.if_pc, bus.if_instr, bus.halted, bus.imem_addr);
    end
    step();
    checks++;
    if (bus.if_pc !== 16'd24 || bus.halted !== 1'b0 || bus.imem_addr !== 16'd28) begin
      failures++;
      $display("FAIL halt_off_next: pc=%h halted=%b addr=%h, required 0018/0/001C",
               bus.if_pc, bus.halted, bus.imem_addr);
    end
`endif
    $display("halt: pc=%h halted=%b addr=%h", bus.if_pc, bus.halted, bus.imem_addr);
    place_halt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_wrap();
    test_reset_midstream();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
